// File: rtl/frame_pkg.sv
// Shared types and sizing helpers for the frame capture/readout path.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  localparam int DEF_W      = 430;
  localparam int DEF_H      = 554;
  localparam int FRAME_SIZE = DEF_W * DEF_H;

  // Minimum address width able to index n pixels.
  function automatic int addr_w_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_capture_reader_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, no reset.
module frame_ram #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/frame_capture_reader.sv
// Captures one W*H frame from the filter stream into RAM, then replays it
// on a ready/valid port through a 2-entry skid stage.
module frame_capture_reader
  import frame_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int H      = DEF_H,
  parameter int ADDR_W = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_in,
  input  logic       vld_in,
  input  logic       cap_en,
  input  logic       rd_start,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       rd_last,
  output logic       frame_done,
  output logic       busy,
  output logic       ovf_err,
  output logic [1:0] state_dbg
);

  localparam int FRAME_LEN = W * H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  if (ADDR_W < addr_w_for(FRAME_LEN)) begin : g_addr_chk
    $fatal(1, "ADDR_W too small for W*H");
  end

  // Read port: a transfer happens on rd_valid & rd_ready; once rd_valid is
  // high, rd_data/rd_last/rd_valid hold until that transfer occurs.
  state_t            state, state_nx;
  logic              wr_en, cap_last, ovf_set, ovf_clr, issue, pop;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic              issue_done, pend, pend_last;
  logic              sk_valid, sk_last;
  logic [7:0]        sk_data, ram_q;
  logic [1:0]        occ;

  assign pop       = rd_valid & rd_ready;
  assign occ       = {1'b0, rd_valid} + {1'b0, sk_valid} + {1'b0, pend};
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    cap_last = 1'b0;
    ovf_set  = 1'b0;
    ovf_clr  = 1'b0;
    issue    = 1'b0;
    case (state)
      ST_IDLE: if (cap_en) state_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        if (vld_in) begin
          wr_en = 1'b1;
          if (wr_cnt == LAST_IDX) begin
            cap_last = 1'b1;
            state_nx = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        ovf_set = vld_in;
        if (cap_en) begin
          ovf_clr  = 1'b1;
          state_nx = ST_CAPTURE;
        end else if (rd_start) begin
          // Address 0 is fetched in the start cycle to meet first-valid latency.
          issue    = 1'b1;
          state_nx = ST_READOUT;
        end
      end
      ST_READOUT: begin
        ovf_set = vld_in;
        // Fetch only if skid entries + in-flight read stay within 2 after this pop.
        issue = !issue_done && ((occ - {1'b0, pop}) < 2'd2);
        if (pop && rd_last) state_nx = ST_FULL;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      wr_cnt     <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx == ST_CAPTURE) || (state_nx == ST_READOUT);
      frame_done <= cap_last;
      if (ovf_clr)      ovf_err <= 1'b0;
      else if (ovf_set) ovf_err <= 1'b1;
      if (wr_en)                    wr_cnt <= cap_last ? '0 : wr_cnt + 1'b1;
      else if (state != ST_CAPTURE) wr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt     <= '0;
      issue_done <= 1'b0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (rd_cnt == LAST_IDX);
      if (issue) begin
        issue_done <= (rd_cnt == LAST_IDX);
        rd_cnt     <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
      end else if (state != ST_READOUT) begin
        issue_done <= 1'b0;
        rd_cnt     <= '0;
      end
    end
  end

  // Head register drives the port; the second entry absorbs a read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      sk_valid <= 1'b0;
      sk_last  <= 1'b0;
      sk_data  <= '0;
    end else if (pop || !rd_valid) begin
      if (sk_valid) begin
        rd_data  <= sk_data;
        rd_last  <= sk_last;
        rd_valid <= 1'b1;
        sk_valid <= pend;
        sk_data  <= ram_q;
        sk_last  <= pend_last;
      end else begin
        rd_valid <= pend;
        rd_last  <= pend_last;
        if (pend) rd_data <= ram_q;
      end
    end else if (pend) begin
      sk_valid <= 1'b1;
      sk_data  <= ram_q;
      sk_last  <= pend_last;
    end
  end

  frame_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (pixel_in),
    .re    (issue),
    .raddr (rd_cnt),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_frame_capture_reader.sv
// Directed bench for frame_capture_reader (W=4, H=3) with a queue scoreboard
// fed by the readout tasks and drained by a negedge monitor.
module tb_frame_capture_reader;

  localparam int NPIX = 12;
  localparam logic [1:0] S_IDLE = 2'd0, S_CAP = 2'd1, S_FULL = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       vld_in = 1'b0, cap_en = 1'b0, rd_start = 1'b0, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, frame_done, busy, ovf_err;
  logic [1:0] state_dbg;

  int checks = 0, errors = 0, xfer_cnt = 0, done_cnt = 0;
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;
  int gaps[NPIX] = '{0, 1, 2, 0, 0, 2, 1, 0, 2, 1, 0, 0};

  frame_capture_reader #(.W(4), .H(3), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .vld_in(vld_in),
    .cap_en(cap_en), .rd_start(rd_start), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .frame_done(frame_done), .busy(busy), .ovf_err(ovf_err),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every transfer, hold check on every stall.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (prev_stall)
      check("stall_hold", {rd_valid, rd_last, rd_data}, {1'b1, prev_word});
    if (rd_valid && rd_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer actual=%0h expected=none", {rd_last, rd_data});
      end else begin
        check("rd_word", {rd_last, rd_data}, exp_q.pop_front());
      end
    end
    prev_stall = rd_valid && !rd_ready;
    prev_word  = {rd_last, rd_data};
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_capture();
    cap_en = 1'b1; vld_in = 1'b1; pixel_in = 8'hEE;  // beat with cap_en is dropped
    tick();
    cap_en = 1'b0; vld_in = 1'b0;
  endtask

  task automatic send_beats(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) tick();
      vld_in = 1'b1; pixel_in = base + 8'(i);
      tick();
      vld_in = 1'b0;
    end
  endtask

  task automatic readout(input logic [7:0] base, input bit rand_ready, output int cycles);
    int x0, n;
    for (int i = 0; i < NPIX; i++) exp_q.push_back({(i == NPIX - 1), base + 8'(i)});
    x0 = xfer_cnt;
    rd_ready = 1'b1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rd_ready = 1'b1;
    check("xfer_count", xfer_cnt - x0, NPIX);
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    check("valid_after_last", rd_valid, 1'b0);
    check("state_after_read", state_dbg, S_FULL);
    cycles = n;
  endtask

  initial begin
    int cyc;
    // Reset state
    #12;
    check("rst_outputs", {rd_data, rd_valid, rd_last, frame_done, busy, ovf_err}, '0);
    check("rst_state", state_dbg, S_IDLE);
    tick();
    rst_n = 1'b1;
    tick();

    // First capture 0x10..0x1B
    arm_capture();
    check("busy_capture", {busy, state_dbg}, {1'b1, S_CAP});
    send_beats(8'h10, NPIX);
    check("frame_done_pulse", frame_done, 1'b1);
    check("full_after_cap", {busy, state_dbg}, {1'b0, S_FULL});
    tick();
    check("frame_done_one_cycle", frame_done, 1'b0);
    check("done_count_1", done_cnt, 1);

    // Readout with rd_ready held high: 12 back-to-back transfers
    readout(8'h10, 1'b0, cyc);
    check("no_bubbles", (cyc <= NPIX + 1), 1'b1);

    // Random-ready readout, then a replay
    readout(8'h10, 1'b1, cyc);
    readout(8'h10, 1'b1, cyc);

    // Overflow in FULL: flag sets, RAM untouched
    send_beats(8'hA0, 3);
    tick();
    check("ovf_set", ovf_err, 1'b1);
    readout(8'h10, 1'b0, cyc);
    check("ovf_sticky", ovf_err, 1'b1);

    // cap_en and rd_start together: capture wins, ovf clears
    cap_en = 1'b1; rd_start = 1'b1;
    tick();
    cap_en = 1'b0; rd_start = 1'b0;
    check("both_state", {busy, state_dbg}, {1'b1, S_CAP});
    check("ovf_cleared", ovf_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_valid_in_cap", rd_valid, 1'b0);
    end

    // New frame overwrites old
    send_beats(8'h20, NPIX);
    check("frame_done_2", frame_done, 1'b1);
    tick();
    readout(8'h20, 1'b0, cyc);

    // Reset mid-capture
    arm_capture();
    send_beats(8'h40, 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {rd_data, rd_valid, rd_last, frame_done, busy, ovf_err}, '0);
    check("async_rst_state", state_dbg, S_IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_ignores_rd_start", {rd_valid, busy, state_dbg}, {1'b0, 1'b0, S_IDLE});
    end
    check("done_count_total", done_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
